cpu_sram_arbiter: RTL
=====================

# cpu_sram_arbiter

Shares the single SRAM-like memory port of the CPU core between the instruction-fetch requester (IF stage) and the data requester (EX/MEM stages). It arbitrates new requests, holds a grant stable until the slave accepts it, and records the source of every accepted request so that in-order `data_ok` responses are routed back to the right requester. It sits between the pipeline stages and the SRAM-like-to-AXI bridge.

## Interface
- `OUTSTANDING`, 2, max accepted-but-unanswered requests (power of two, 2..8)
- `clk`  in  1  core clock
- `resetn`  in  1  asynchronous, active-low reset
- `inst_req` / `data_req`  in  1  request valid from IF / MEM requester
- `inst_wr` / `data_wr`  in  1  1 = write
- `inst_size` / `data_size`  in  2  0 = byte, 1 = half, 2 = word
- `inst_wstrb` / `data_wstrb`  in  4  byte write strobes
- `inst_addr` / `data_addr`  in  32  byte address
- `inst_wdata` / `data_wdata`  in  32  write data
- `inst_addr_ok` / `data_addr_ok`  out  1  request accepted this cycle
- `inst_data_ok` / `data_data_ok`  out  1  response for this requester this cycle
- `inst_rdata` / `data_rdata`  out  32  read data (valid with `*_data_ok`)
- `sram_req`, `sram_wr`, `sram_size[1:0]`, `sram_wstrb[3:0]`, `sram_addr[31:0]`, `sram_wdata[31:0]`  out  request to slave
- `sram_addr_ok`, `sram_data_ok`  in  1  slave handshakes
- `sram_rdata`  in  32  slave read data

## Operation
- Grant selection (no lock held): `data_req` wins over `inst_req` (base policy). Selected requester's fields drive all `sram_*` request outputs; unselected fields ignored.
- `sram_req = selected_req & ~full`. `full` = outstanding count == `OUTSTANDING`, evaluated on the registered count (a same-cycle pop does not free a slot).
- Handshake: `sram_req & sram_addr_ok`. The granted requester alone sees `*_addr_ok = 1` that cycle; the other sees 0.
- Grant lock: if `sram_req = 1` and `sram_addr_ok = 0`, latch the granted source in a lock register; next cycles keep that grant regardless of the other requester until handshake. Lock clears on handshake. If the locked requester drops `req` (protocol violation), lock clears and arbitration resumes.
- Source FIFO: depth `OUTSTANDING`, 1-bit entries (0 = inst, 1 = data). Push granted source on handshake; pop on `sram_data_ok` when not empty. Push and pop in the same cycle are both performed; count unchanged.
- Response routing: `sram_data_ok` asserts `inst_data_ok` or `data_data_ok` per FIFO head. `sram_rdata` drives both `*_rdata` unconditionally.
- `sram_data_ok` with FIFO empty: ignored, no pop, no output asserted.
- Pointers wrap modulo `OUTSTANDING`; count is `$clog2(OUTSTANDING)+1` bits.

## Timing
- Request path combinational: requester `req` -> `sram_req` same cycle; `sram_addr_ok` -> `*_addr_ok` same cycle.
- Response path combinational: `sram_data_ok` -> `*_data_ok` same cycle, zero added latency.
- Only state: lock valid + lock source, FIFO storage, read/write pointers, count.
- Reset (`resetn` low, any cycle incl. mid-transaction): lock cleared, pointers and count 0, FIFO empty immediately (asynchronous). Outputs with all inputs 0: all 0. Responses from pre-reset requests are not supported; slave is reset together.
- A request accepted in cycle N may receive `data_ok` in cycle N+1 or later, never cycle N.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: when both requesters are active and no lock is held, grant alternates; a 1-bit last-winner register (reset = inst, so data wins first) updates on each handshake; loser of the last handshake wins next contest.
- Undefined: fixed priority, data over inst; last-winner register not built.

## Test plan
- Single inst read: `inst_req=1, addr=0x1C000000`, slave `addr_ok` cycle 0, `data_ok` cycle 2 with `rdata=0x02C00000` -> `inst_addr_ok` cycle 0, `inst_data_ok` cycle 2, `data_*_ok` stay 0.
- Contention: both req at cycle 0, slave ready -> data granted (`sram_addr=data_addr`); inst granted cycle 1 (fixed) / inst granted cycle 1 and data next contest (round-robin, over 4 contests 2 each).
- Lock: inst req alone, `sram_addr_ok=0` for 3 cycles, data_req rises cycle 1 -> `sram_addr` stays inst address until handshake cycle 3; data granted cycle 4.
- Full: `OUTSTANDING=2`, two accepted, no `data_ok` -> `sram_req=0` for a third; `data_ok` in cycle K -> `sram_req` reasserts cycle K+1.
- Ordering: accept data, inst, data; three `data_ok` -> routed data, inst, data; simultaneous push/pop keeps count.
- Reset mid-op with 2 outstanding -> count 0, spurious `sram_data_ok` after reset produces no `*_data_ok`.

Source files
------------

// File: rtl/cpu_sram_arbiter.sv
// Arbiter sharing one SRAM-like port between the IF and MEM requesters, with
// in-order response routing. Define ARB_ROUND_ROBIN_EN for alternating grants.
module cpu_sram_arbiter #(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata
);

    localparam int unsigned PW = $clog2(OUTSTANDING);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    logic          r_lock_vld;
    src_e          r_lock_src;
    src_e          r_fifo [OUTSTANDING];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
`ifdef ARB_ROUND_ROBIN_EN
    src_e          r_last_win;
`endif

    src_e w_sel;
    src_e w_head;
    logic w_lock_hold;
    logic w_sel_req;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(OUTSTANDING));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rptr];

    // A lock only holds while its owner keeps requesting; a dropped request
    // releases it and arbitration resumes in the same cycle.
    always_comb begin
        w_lock_hold = r_lock_vld && ((r_lock_src == SRC_DATA) ? data_req : inst_req);
        w_sel       = SRC_INST;
        if (w_lock_hold) begin
            w_sel = r_lock_src;
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            if (data_req && inst_req)
                w_sel = (r_last_win == SRC_INST) ? SRC_DATA : SRC_INST;
            else
                w_sel = data_req ? SRC_DATA : SRC_INST;
`else
            w_sel = data_req ? SRC_DATA : SRC_INST;
`endif
        end
    end

    always_comb begin
        if (w_sel == SRC_DATA) begin
            w_sel_req  = data_req;
            sram_wr    = data_wr;
            sram_size  = data_size;
            sram_wstrb = data_wstrb;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else begin
            w_sel_req  = inst_req;
            sram_wr    = inst_wr;
            sram_size  = inst_size;
            sram_wstrb = inst_wstrb;
            sram_addr  = inst_addr;
            sram_wdata = inst_wdata;
        end
    end

    assign sram_req     = w_sel_req & ~w_full;
    assign w_push       = sram_req & sram_addr_ok;
    assign w_pop        = sram_data_ok & ~w_empty;
    assign inst_addr_ok = w_push & (w_sel == SRC_INST);
    assign data_addr_ok = w_push & (w_sel == SRC_DATA);
    assign inst_data_ok = w_pop & (w_head == SRC_INST);
    assign data_data_ok = w_pop & (w_head == SRC_DATA);
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lock_vld <= 1'b0;
            r_lock_src <= SRC_INST;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            for (int unsigned i = 0; i < OUTSTANDING; i++)
                r_fifo[i] <= SRC_INST;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_win <= SRC_INST;
`endif
        end else begin
            if (w_push) begin
                r_lock_vld <= 1'b0;
            end else if (sram_req) begin
                r_lock_vld <= 1'b1;
                r_lock_src <= w_sel;
            end else if (r_lock_vld && !w_lock_hold) begin
                r_lock_vld <= 1'b0;
            end

            if (w_push) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= r_wptr + 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                r_last_win     <= w_sel;
`endif
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
